vc_pop_arbiter: RTL and testbench
=================================

Name: vc_pop_arbiter

Overview:
- Read-side controller for the two virtual-channel FIFOs (VC0, VC1) in the transmission path.
- Decides which VC to pop each cycle and captures the returned word. It then pushes the word into one of two downstream destination FIFOs (D0, D1), selected by a routing bit in the word.
- Strict VC0 priority with head-of-line bypass. Respects downstream almost-full backpressure.

Parameters:
- DATA_WIDTH, 6, width of every data word; bit DATA_WIDTH-1 is the destination select (0 = D0, 1 = D1).

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- reset  in  1  asynchronous active-low reset.
- init  in  1  synchronous soft-init, active-low; 0 flushes the block the same way as reset.
- empty_vc0, empty_vc1  in  1  FIFO empty flags.
- head_vc0, head_vc1  in  DATA_WIDTH  FIFO next-word peek (registered at the FIFO; stale for one cycle after a pop).
- rdata_vc0, rdata_vc1  in  DATA_WIDTH  FIFO read data; valid the cycle after the pop.
- almost_full_d0, almost_full_d1  in  1  downstream backpressure.
- pop_vc0, pop_vc1  out  1  FIFO read enables (combinational from state and inputs).
- push_d0, push_d1  out  1  destination write enables (registered).
- data_out  out  DATA_WIDTH  word to the destinations (registered).
- idle  out  1  high when no pop is in flight and both VCs are empty.

Behaviour:
- Reset (reset = 0, async) or init = 0 (sync):
  - state = IDLE; pipeline valid bits cleared; push_d0 = push_d1 = 0; data_out = 0.
  - pop_vc0 = pop_vc1 = 0; idle = 1; block flags cleared.
- States:
  - IDLE: stay while both VCs are empty; go to ACTIVE when either empty flag is low.
  - ACTIVE: go to IDLE when both VCs are empty and the pipeline is empty.
- Pop eligibility for VCx (ACTIVE only):
  - !empty_vcx;
  - the destination of head_vcx is not almost_full;
  - VCx was not popped in the previous cycle (peek refresh rule).
- Selection:
  - pop_vc0 when VC0 is eligible.
  - Otherwise pop_vc1 when VC1 is eligible (bypass allowed when the VC0 head is blocked or VC0 is refreshing).
  - Never both in one cycle.
- Pipeline (pop in cycle N):
  - Stage 1, end of N: register src VC and dest bit from the head used for the decision.
  - Stage 2, end of N+1: data_out <= rdata of src; push_d<dest> <= 1, the other push <= 0.
  - The push is visible during cycle N+2. Fixed latency of 2 cycles from pop to push.
- With no stage-2 capture, push_d0 = push_d1 = 0 and data_out holds its last value.
- Throughput:
  - One push per cycle maximum.
  - Single VC alone gives one pop every 2 cycles; two VCs alternating give one per cycle.
- Backpressure:
  - almost_full is sampled at pop time only; words already in flight (max 2) always complete.
  - Downstream thresholds must leave at least 2 entries of margin.
- Destination bit: dest = head[DATA_WIDTH-1], taken from the head at pop time; the word is forwarded unmodified.
- init deasserted mid-operation: words in flight are dropped, no push is issued, FIFOs are not popped further.
- idle = (state == IDLE) and no valid stage bits.

Optional Feature:
- Macro: VC_POP_ARBITER_COUNTERS_EN.
- With it: extra outputs cnt_d0 and cnt_d1, 8 bits each.
  - Each increments by 1 on each cycle its push is high, wrapping 255 -> 0.
  - Both clear on reset or init = 0.
- Without it: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- VC0 holds 3 words, head bit5 = 0, D0 not full -> pop_vc0 in cycles 0, 2, 4; push_d0 in cycles 2, 4, 6 with the matching data; push_d1 never high.
- Both VCs hold 4 words, all dest D1 -> pops alternate VC0, VC1, VC0, ... one per cycle; 8 push_d1 pulses back-to-back; VC0 words appear first in each pair.
- VC0 head dest D0 with almost_full_d0 = 1; VC1 head dest D1 -> only pop_vc1 fires; after almost_full_d0 drops, pop_vc0 fires in the next eligible cycle.
- Word 6'b100101 popped; init driven low in cycle N+1 -> no push_d1 in N+2; data_out = 0; idle = 1.
- Async reset asserted between clock edges while ACTIVE -> push and pop outputs drop to 0 immediately, without waiting for a clock edge; after release with both FIFOs empty, idle = 1.
- With VC_POP_ARBITER_COUNTERS_EN defined: 257 pushes to D0 -> cnt_d0 = 1, cnt_d1 = 0.

Source files
------------

// File: rtl/vc_pop_arbiter.sv
// Read-side arbiter for two VC FIFOs: strict VC0 priority with head-of-line bypass, 2-cycle pop-to-push pipeline.
// Optional per-destination push counters (cnt_d0/cnt_d1) are enabled by defining VC_POP_ARBITER_COUNTERS_EN.
module vc_pop_arbiter #(
  parameter int DATA_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  empty_vc0,
  input  logic                  empty_vc1,
  input  logic [DATA_WIDTH-1:0] head_vc0,
  input  logic [DATA_WIDTH-1:0] head_vc1,
  input  logic [DATA_WIDTH-1:0] rdata_vc0,
  input  logic [DATA_WIDTH-1:0] rdata_vc1,
  input  logic                  almost_full_d0,
  input  logic                  almost_full_d1,
  output logic                  pop_vc0,
  output logic                  pop_vc1,
  output logic                  push_d0,
  output logic                  push_d1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  idle
`ifdef VC_POP_ARBITER_COUNTERS_EN
  ,
  output logic [7:0]            cnt_d0,
  output logic [7:0]            cnt_d1
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t                state_r;
  logic                  s1_valid_r;
  logic                  s1_src_r;
  logic                  s1_dest_r;
  logic                  push_d0_r;
  logic                  push_d1_r;
  logic [DATA_WIDTH-1:0] data_out_r;

  logic                  blocked_vc0_s;
  logic                  blocked_vc1_s;
  logic                  elig_vc0_s;
  logic                  elig_vc1_s;
  logic                  pop_vc0_s;
  logic                  pop_vc1_s;
  logic                  pipe_busy_s;
  logic                  unused_head_s;

  function automatic logic dest_full(input logic [DATA_WIDTH-1:0] head,
                                     input logic                  af0,
                                     input logic                  af1);
    dest_full = head[DATA_WIDTH-1] ? af1 : af0;
  endfunction

  // Only the routing bit of each head word steers the decision.
  assign unused_head_s = ^{head_vc0[DATA_WIDTH-2:0], head_vc1[DATA_WIDTH-2:0]};

  // Pop decision; a VC popped last cycle is skipped because its head peek is still stale.
  always_comb begin
    blocked_vc0_s = dest_full(head_vc0, almost_full_d0, almost_full_d1);
    blocked_vc1_s = dest_full(head_vc1, almost_full_d0, almost_full_d1);
    elig_vc0_s    = (state_r == ST_ACTIVE) && init && !empty_vc0 && !blocked_vc0_s
                    && !(s1_valid_r && !s1_src_r);
    elig_vc1_s    = (state_r == ST_ACTIVE) && init && !empty_vc1 && !blocked_vc1_s
                    && !(s1_valid_r && s1_src_r);
    pop_vc0_s     = elig_vc0_s;
    pop_vc1_s     = elig_vc1_s && !elig_vc0_s;
  end

  assign pipe_busy_s = s1_valid_r || push_d0_r || push_d1_r;

  // State machine plus the two pipeline stages (decision capture, then data capture and push).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      s1_valid_r <= 1'b0;
      s1_src_r   <= 1'b0;
      s1_dest_r  <= 1'b0;
      push_d0_r  <= 1'b0;
      push_d1_r  <= 1'b0;
      data_out_r <= {DATA_WIDTH{1'b0}};
    end else if (!init) begin
      state_r    <= ST_IDLE;
      s1_valid_r <= 1'b0;
      s1_src_r   <= 1'b0;
      s1_dest_r  <= 1'b0;
      push_d0_r  <= 1'b0;
      push_d1_r  <= 1'b0;
      data_out_r <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE:   if (!empty_vc0 || !empty_vc1) state_r <= ST_ACTIVE;
        ST_ACTIVE: if (empty_vc0 && empty_vc1 && !pipe_busy_s) state_r <= ST_IDLE;
        default:   state_r <= ST_IDLE;
      endcase
      s1_valid_r <= pop_vc0_s || pop_vc1_s;
      s1_src_r   <= pop_vc1_s;
      s1_dest_r  <= pop_vc1_s ? head_vc1[DATA_WIDTH-1] : head_vc0[DATA_WIDTH-1];
      push_d0_r  <= s1_valid_r && !s1_dest_r;
      push_d1_r  <= s1_valid_r && s1_dest_r;
      if (s1_valid_r) begin
        data_out_r <= s1_src_r ? rdata_vc1 : rdata_vc0;
      end
    end
  end

  assign pop_vc0  = pop_vc0_s;
  assign pop_vc1  = pop_vc1_s;
  assign push_d0  = push_d0_r;
  assign push_d1  = push_d1_r;
  assign data_out = data_out_r;
  assign idle     = (state_r == ST_IDLE) && !pipe_busy_s;

`ifdef VC_POP_ARBITER_COUNTERS_EN
  logic [7:0] cnt_d0_r;
  logic [7:0] cnt_d1_r;

  // Free-running push counters per destination, wrapping at 8 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_d0_r <= 8'd0;
      cnt_d1_r <= 8'd0;
    end else if (!init) begin
      cnt_d0_r <= 8'd0;
      cnt_d1_r <= 8'd0;
    end else begin
      if (push_d0_r) cnt_d0_r <= cnt_d0_r + 8'd1;
      if (push_d1_r) cnt_d1_r <= cnt_d1_r + 8'd1;
    end
  end

  assign cnt_d0 = cnt_d0_r;
  assign cnt_d1 = cnt_d1_r;
`endif

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Self-checking bench for vc_pop_arbiter: FIFO models, queue-based reference model, directed scenarios.
`timescale 1ns/1ps
module tb_vc_pop_arbiter;
  localparam int W = 6;

  logic clk = 1'b0;
  logic reset, init, empty_vc0, empty_vc1, almost_full_d0, almost_full_d1;
  logic [W-1:0] head_vc0, head_vc1, rdata_vc0, rdata_vc1, data_out;
  logic pop_vc0, pop_vc1, push_d0, push_d1, idle;
`ifdef VC_POP_ARBITER_COUNTERS_EN
  logic [7:0] cnt_d0, cnt_d1;
`endif

  vc_pop_arbiter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .init(init),
    .empty_vc0(empty_vc0), .empty_vc1(empty_vc1),
    .head_vc0(head_vc0), .head_vc1(head_vc1),
    .rdata_vc0(rdata_vc0), .rdata_vc1(rdata_vc1),
    .almost_full_d0(almost_full_d0), .almost_full_d1(almost_full_d1),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .push_d0(push_d0), .push_d1(push_d1),
    .data_out(data_out), .idle(idle)
`ifdef VC_POP_ARBITER_COUNTERS_EN
    , .cnt_d0(cnt_d0), .cnt_d1(cnt_d1)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO contents and reference model state
  typedef struct {
    int           due;
    logic         dest;
    logic [W-1:0] data;
  } tr_t;
  tr_t          pend[$];
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int           cyc = 0;
  bit           m_active = 1'b0;
  int           m_last = -1;
  logic [W-1:0] m_data = 6'd0;
  logic [7:0]   m_cnt0 = 8'd0;
  logic [7:0]   m_cnt1 = 8'd0;
  logic         e_p0, e_p1, e_pd0, e_pd1, busy;
  logic [W-1:0] e_do;
  logic         s_pop0 = 1'b0;
  logic         s_pop1 = 1'b0;

  int           pop_cyc[$];
  int           pop_vc[$];
  int           push_cyc[$];
  int           push_dst[$];
  int           push_dat[$];

  function automatic logic dest_af(input logic [W-1:0] h);
    return h[W-1] ? almost_full_d1 : almost_full_d0;
  endfunction

  function automatic int pcy(input int i); return (i < pop_cyc.size())  ? pop_cyc[i]  : -100; endfunction
  function automatic int pvc(input int i); return (i < pop_vc.size())   ? pop_vc[i]   : -1;   endfunction
  function automatic int hcy(input int i); return (i < push_cyc.size()) ? push_cyc[i] : -100; endfunction
  function automatic int hds(input int i); return (i < push_dst.size()) ? push_dst[i] : -1;   endfunction
  function automatic int hdt(input int i); return (i < push_dat.size()) ? push_dat[i] : -1;   endfunction

  // Compare at the falling edge, then advance model and FIFOs just after the rising edge.
  always begin
    @(negedge clk);
    e_pd0 = 1'b0;
    e_pd1 = 1'b0;
    e_do  = m_data;
    if (!reset) begin
      e_p0 = 1'b0;
      e_p1 = 1'b0;
      e_do = 6'd0;
    end else begin
      e_p0 = m_active && init && !empty_vc0 && !dest_af(head_vc0) && (m_last != 0);
      e_p1 = m_active && init && !e_p0 && !empty_vc1 && !dest_af(head_vc1) && (m_last != 1);
      foreach (pend[i]) begin
        if (pend[i].due == cyc) begin
          e_pd0 = !pend[i].dest;
          e_pd1 = pend[i].dest;
          e_do  = pend[i].data;
        end
      end
    end
    chk("pop_vc0", 32'(pop_vc0), 32'(e_p0));
    chk("pop_vc1", 32'(pop_vc1), 32'(e_p1));
    chk("push_d0", 32'(push_d0), 32'(e_pd0));
    chk("push_d1", 32'(push_d1), 32'(e_pd1));
    chk("data_out", 32'(data_out), 32'(e_do));
    chk("idle", 32'(idle), reset ? 32'(!m_active) : 32'd1);
`ifdef VC_POP_ARBITER_COUNTERS_EN
    chk("cnt_d0", 32'(cnt_d0), 32'(reset ? m_cnt0 : 8'd0));
    chk("cnt_d1", 32'(cnt_d1), 32'(reset ? m_cnt1 : 8'd0));
`endif
    if (pop_vc0) begin pop_cyc.push_back(cyc); pop_vc.push_back(0); end
    if (pop_vc1) begin pop_cyc.push_back(cyc); pop_vc.push_back(1); end
    if (push_d0 || push_d1) begin
      push_cyc.push_back(cyc);
      push_dst.push_back(push_d1 ? 1 : 0);
      push_dat.push_back(int'(data_out));
    end
    s_pop0 = pop_vc0;
    s_pop1 = pop_vc1;

    @(posedge clk);
    #1;
    if (!reset || !init) begin
      pend.delete();
      m_active = 1'b0;
      m_last   = -1;
      m_data   = 6'd0;
      m_cnt0   = 8'd0;
      m_cnt1   = 8'd0;
    end else begin
      if (m_active) begin
        busy = 1'b0;
        foreach (pend[i]) if (pend[i].due == cyc || pend[i].due == cyc + 1) busy = 1'b1;
        if (empty_vc0 && empty_vc1 && !busy) m_active = 1'b0;
      end else begin
        m_active = !empty_vc0 || !empty_vc1;
      end
      if (e_p0 && q0.size() > 0) pend.push_back('{cyc + 2, q0[0][W-1], q0[0]});
      if (e_p1 && q1.size() > 0) pend.push_back('{cyc + 2, q1[0][W-1], q1[0]});
      m_last = e_p0 ? 0 : (e_p1 ? 1 : -1);
      m_data = e_do;
      if (e_pd0) m_cnt0 = m_cnt0 + 8'd1;
      if (e_pd1) m_cnt1 = m_cnt1 + 8'd1;
    end
    // FIFO models: read data appears after the pop, head peek lags one cycle behind a pop
    if (s_pop0 && q0.size() > 0) rdata_vc0 = q0.pop_front();
    else if (q0.size() > 0) head_vc0 = q0[0];
    if (s_pop1 && q1.size() > 0) rdata_vc1 = q1.pop_front();
    else if (q1.size() > 0) head_vc1 = q1[0];
    empty_vc0 = (q0.size() == 0);
    empty_vc1 = (q1.size() == 0);
    while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load0(input logic [W-1:0] w);
    if (q0.size() == 0) head_vc0 = w;
    q0.push_back(w);
    empty_vc0 = 1'b0;
  endtask

  task automatic load1(input logic [W-1:0] w);
    if (q1.size() == 0) head_vc1 = w;
    q1.push_back(w);
    empty_vc1 = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    step();
    step();
    while (!(idle && q0.size() == 0 && q1.size() == 0) && n < budget) begin
      step();
      n++;
    end
    chk("wait_idle_in_budget", 32'(n < budget), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  logic [W-1:0] t1w[3] = '{6'b000001, 6'b010010, 6'b001011};
  logic [W-1:0] t2w[8] = '{6'h20, 6'h30, 6'h21, 6'h31, 6'h22, 6'h32, 6'h23, 6'h33};
  int b, bp, n;

  initial begin
    reset = 1'b0; init = 1'b1;
    empty_vc0 = 1'b1; empty_vc1 = 1'b1;
    head_vc0 = 6'd0; head_vc1 = 6'd0; rdata_vc0 = 6'd0; rdata_vc1 = 6'd0;
    almost_full_d0 = 1'b0; almost_full_d1 = 1'b0;
    #12;
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_push", 32'({push_d0, push_d1}), 32'd0);
    chk("rst_pop", 32'({pop_vc0, pop_vc1}), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    step();
    reset = 1'b1;
    step();

    // Single VC: one pop every other cycle, pushes two cycles later
    b = pop_cyc.size(); bp = push_cyc.size();
    for (int i = 0; i < 3; i++) load0(t1w[i]);
    wait_idle(40);
    chk("t1_pops", 32'(pop_cyc.size() - b), 32'd3);
    chk("t1_pushes", 32'(push_cyc.size() - bp), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_pop_vc", 32'(pvc(b + i)), 32'd0);
      chk("t1_pop_cyc", 32'(pcy(b + i) - pcy(b)), 32'(2 * i));
      chk("t1_push_cyc", 32'(hcy(bp + i) - pcy(b)), 32'(2 * i + 2));
      chk("t1_push_dest", 32'(hds(bp + i)), 32'd0);
      chk("t1_push_data", 32'(hdt(bp + i)), 32'(t1w[i]));
    end

    // Both VCs to D1: alternating pops, back-to-back pushes, VC0 first
    b = pop_cyc.size(); bp = push_cyc.size();
    for (int i = 0; i < 4; i++) begin
      load0(t2w[2 * i]);
      load1(t2w[2 * i + 1]);
    end
    wait_idle(40);
    chk("t2_pushes", 32'(push_cyc.size() - bp), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t2_pop_vc", 32'(pvc(b + i)), 32'(i % 2));
      chk("t2_pop_cyc", 32'(pcy(b + i) - pcy(b)), 32'(i));
      chk("t2_push_cyc", 32'(hcy(bp + i) - hcy(bp)), 32'(i));
      chk("t2_push_dest", 32'(hds(bp + i)), 32'd1);
      chk("t2_push_data", 32'(hdt(bp + i)), 32'(t2w[i]));
    end

    // VC0 blocked by almost_full_d0: VC1 bypasses, VC0 goes once released
    b = pop_cyc.size(); bp = push_cyc.size();
    almost_full_d0 = 1'b1;
    load0(6'b000111);
    load1(6'b100001);
    load1(6'b100010);
    for (int i = 0; i < 6; i++) step();
    chk("t3_vc1_pops", 32'(pop_cyc.size() - b), 32'd2);
    chk("t3_first_vc", 32'(pvc(b)), 32'd1);
    chk("t3_second_vc", 32'(pvc(b + 1)), 32'd1);
    almost_full_d0 = 1'b0;
    #1;
    chk("t3_vc0_released", 32'(pop_vc0), 32'd1);
    wait_idle(20);
    chk("t3_pushes", 32'(push_cyc.size() - bp), 32'd3);
    chk("t3_last_dest", 32'(hds(bp + 2)), 32'd0);
    chk("t3_last_data", 32'(hdt(bp + 2)), 32'(6'b000111));

    // init low while a D1 word is in flight: dropped
    bp = push_cyc.size();
    load0(6'b100101);
    n = 0;
    while (!pop_vc0 && n < 10) begin step(); n++; end
    chk("t4_popped", 32'(pop_vc0), 32'd1);
    step();
    init = 1'b0;
    step();
    init = 1'b1;
    #1;
    chk("t4_no_push_d1", 32'(push_d1), 32'd0);
    chk("t4_data_zero", 32'(data_out), 32'd0);
    chk("t4_idle", 32'(idle), 32'd1);
    step();
    step();
    chk("t4_never_pushed", 32'(push_cyc.size() - bp), 32'd0);

    // Async reset mid-traffic drops outputs without a clock edge
    load0(6'b000001); load0(6'b000010);
    load1(6'b100011); load1(6'b100100);
    n = 0;
    while (!(push_d0 || push_d1) && n < 10) begin step(); n++; end
    chk("t5_busy", 32'(push_d0 || push_d1), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("t5_pop_drop", 32'({pop_vc0, pop_vc1}), 32'd0);
    chk("t5_push_drop", 32'({push_d0, push_d1}), 32'd0);
    chk("t5_data_drop", 32'(data_out), 32'd0);
    q0.delete(); q1.delete();
    empty_vc0 = 1'b1; empty_vc1 = 1'b1;
    step(); step();
    reset = 1'b1;
    step(); step();
    chk("t5_idle_after", 32'(idle), 32'd1);

`ifdef VC_POP_ARBITER_COUNTERS_EN
    // 257 pushes to D0 wrap the counter to 1
    for (int i = 0; i < 257; i++) load0({1'b0, 5'(i)});
    wait_idle(700);
    chk("t6_cnt_d0", 32'(cnt_d0), 32'd1);
    chk("t6_cnt_d1", 32'(cnt_d1), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
